// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: serves byte/halfword/word loads and stores from a word
// array after WAIT_STATES wait cycles. Define DMEM_ALIGN_TRAP_EN to trap misaligned accesses.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adres,
  input  logic [1:0]  inMemRead,
  input  logic [1:0]  inMemWrite,
  input  logic [31:0] inWriteReg,
  output logic [31:0] outReadReg,
  output logic        stall,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned AdrW = IdxW + 2;
  localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CntW-1:0] WaitInit = CntW'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AdrW-1:0] adr_q;
  logic [1:0]      rd_q, wr_q;
  logic [31:0]     wdata_q;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic req, capture, enter_resp;

  // Address bits above the array size alias and are deliberately dropped.
  logic unused_adres;
  assign unused_adres = ^adres[31:AdrW];

  assign req = (inMemRead != 2'b00) || (inMemWrite != 2'b00);

  // ---------------------------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    mem_ready  = 1'b0;
    capture    = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          stall   = 1'b1;
          capture = 1'b1;
          cnt_d   = WaitInit;
          if (WAIT_STATES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        stall = 1'b1;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp: begin
        mem_ready = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Access decode. With zero wait states the access completes on the capture edge itself, so
  // the live inputs are used while idle and the latched copy otherwise.
  // ---------------------------------------------------------------------------------------------
  logic [AdrW-1:0] op_adr;
  logic [1:0]      op_rd, op_wr, op_sz, lo;
  logic [31:0]     op_wdata;
  logic            conflict, misalign, bad;
  logic [IdxW-1:0] idx;
  logic [31:0]     word, word_sh, load_val, store_val;
  logic [3:0]      be;
  logic            do_write;

  always_comb begin
    if (state_q == StIdle) begin
      op_adr   = adres[AdrW-1:0];
      op_rd    = inMemRead;
      op_wr    = inMemWrite;
      op_wdata = inWriteReg;
    end else begin
      op_adr   = adr_q;
      op_rd    = rd_q;
      op_wr    = wr_q;
      op_wdata = wdata_q;
    end
  end

  always_comb begin
    op_sz    = (op_rd != 2'b00) ? op_rd : op_wr;
    conflict = (op_rd != 2'b00) && (op_wr != 2'b00);
    misalign = ((op_sz == 2'b10) && op_adr[0]) || ((op_sz == 2'b11) && (op_adr[1:0] != 2'b00));
`ifdef DMEM_ALIGN_TRAP_EN
    bad = conflict || misalign;
    lo  = op_adr[1:0];
`else
    bad = conflict;
    unique case (op_sz)
      2'b10:   lo = {op_adr[1], 1'b0};
      2'b11:   lo = 2'b00;
      default: lo = op_adr[1:0];
    endcase
`endif
  end

  assign idx     = op_adr[AdrW-1:2];
  assign word    = mem_q[idx];
  assign word_sh = word >> {lo, 3'b000};

  always_comb begin
    load_val  = word;
    store_val = op_wdata;
    be        = 4'b0000;
    unique case (op_sz)
      2'b01: begin
        load_val  = {{24{word_sh[7]}}, word_sh[7:0]};
        store_val = {4{op_wdata[7:0]}};
        be        = 4'b0001 << lo;
      end
      2'b10: begin
        load_val  = {{16{word_sh[15]}}, word_sh[15:0]};
        store_val = {2{op_wdata[15:0]}};
        be        = lo[1] ? 4'b1100 : 4'b0011;
      end
      2'b11: begin
        load_val  = word;
        store_val = op_wdata;
        be        = 4'b1111;
      end
      default: ;
    endcase
  end

  assign do_write = enter_resp && !bad && (op_wr != 2'b00);

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d = bad;
      if (!bad && (op_rd != 2'b00)) begin
        rdata_d = load_val;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      adr_q   <= '0;
      rd_q    <= 2'b00;
      wr_q    <= 2'b00;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (capture) begin
        adr_q   <= adres[AdrW-1:0];
        rd_q    <= inMemRead;
        wr_q    <= inMemWrite;
        wdata_q <= inWriteReg;
      end
    end
  end

  // Array is not cleared by reset; reset only suppresses a write pending on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          mem_q[idx][8*k +: 8] <= store_val[8*k +: 8];
        end
      end
    end
  end

  assign outReadReg = rdata_q;
  assign mem_err    = (state_q == StResp) && err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the datapath's load/store interface. It accepts the address, read-size, write-size and store-data signals the datapath drives, and returns load data.
- Serves each access from an internal word array after a programmable number of wait states.
- Asserts a stall to the pipeline while an access is outstanding.
- Replaces the zero-latency data_memory so the pipelined core can be exercised against realistic memory latency.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two).
- WAIT_STATES, 2, extra cycles between request capture and response (0 allowed).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- adres  in  32  byte address from the ALU.
- inMemRead  in  2  load size: 00 none, 01 byte, 10 halfword, 11 word.
- inMemWrite  in  2  store size, same encoding.
- inWriteReg  in  32  store data, right-aligned.
- outReadReg  out  32  load data; sign-extended for byte/halfword.
- stall  out  1  high while an access is outstanding; the pipeline holds all stages.
- mem_ready  out  1  one-cycle pulse in the response cycle.
- mem_err  out  1  error flag, meaningful only in the response cycle.

Behaviour:
- Reset (rst=1 at an edge):
  - FSM goes to IDLE; outReadReg=0, mem_ready=0, mem_err=0.
  - Array contents are not cleared.
  - rst has priority over every other event, including a pending write.
- FSM states:
  - IDLE: request = (inMemRead!=0) or (inMemWrite!=0). On a request:
    - latch adres, both size fields and inWriteReg;
    - load wait counter = WAIT_STATES;
    - go to WAIT if WAIT_STATES>0, else go to RESP.
  - WAIT: decrement the counter each cycle; at counter==1 go to RESP.
  - RESP: mem_ready=1 for exactly one cycle, then unconditionally return to IDLE.
- stall:
  - combinational: 1 in IDLE when a request is present, 1 throughout WAIT, 0 in RESP;
  - 0 in IDLE with no request.
- Latency: an access stalls the pipeline WAIT_STATES+1 cycles. The pipeline advances at the edge that ends RESP.
- Requester obligation: hold all request inputs stable while stall=1. The responder uses only the latched copy after capture.
- Execution point:
  - The array write and the outReadReg load both occur at the edge entering RESP.
  - outReadReg holds its value until the next completed read; writes do not change it.
- Addressing:
  - word index = adres[log2(DEPTH_WORDS)+1 : 2];
  - higher address bits are ignored, so addresses alias/wrap modulo 4*DEPTH_WORDS;
  - byte lane k occupies bits [8k+7:8k], little-endian.
- Stores:
  - byte writes lane adres[1:0] from inWriteReg[7:0];
  - halfword writes lanes {adres[1],0} and {adres[1],1} from inWriteReg[15:0];
  - word writes all lanes;
  - other lanes are unchanged.
- Loads: the selected byte or halfword is sign-extended to 32 bits; word is returned as-is.
- Read and write both nonzero in one request:
  - illegal; no array access occurs;
  - mem_err=1 in RESP, outReadReg unchanged;
  - timing is identical to a normal access.
- Misalignment: halfword with adres[0]=1, or word with adres[1:0]!=0. Handling depends on DMEM_ALIGN_TRAP_EN (see below).
- Back-to-back: a request present in the cycle after RESP (IDLE) is captured immediately. There are no dead cycles beyond the state sequence.
- Reset while in WAIT or RESP-entry: the access is aborted, no write occurs, and the FSM returns to IDLE.

Optional Feature:
- DMEM_ALIGN_TRAP_EN defined:
  - a misaligned access performs no write;
  - it leaves outReadReg unchanged;
  - it pulses mem_err=1 in RESP.
- Not defined:
  - the offending low address bits are forced to 0 (halfword: bit0; word: bits1:0) and the access proceeds normally;
  - mem_err is driven by the read/write conflict only.
- Timing is identical in both builds.

Test Plan:
- rst=1 for 2 cycles, then idle -> outReadReg=0, stall=0, mem_ready=0, mem_err=0.
- WAIT_STATES=2; word store 0xDEADBEEF to 0x10, then word load from 0x10 -> each access gives stall=1 for exactly 3 cycles, mem_ready pulses once, load returns 0xDEADBEEF.
- Byte store 0x80 to 0x13, then byte load 0x13 and word load 0x10 -> byte load = 0xFFFFFF80, word load = 0x80ADBEEF.
- Halfword load 0x12 after the previous step -> 0xFFFF80AD.
- WAIT_STATES=0, back-to-back:
  - requests: store 0x11223344 to 0x20, then load 0x20;
  - stall=1 one cycle per access;
  - load = 0x11223344;
  - address 0x420 with DEPTH_WORDS=256 aliases to 0x20, so a load from 0x420 also returns 0x11223344.
- Word load from 0x22:
  - with DMEM_ALIGN_TRAP_EN: mem_err=1 and outReadReg unchanged;
  - without: returns 0x11223344.
- read=11 and write=11 together: mem_err=1 and memory unchanged.
- rst asserted in a WAIT cycle of a store 0x55 to 0x30 -> FSM returns to IDLE, and a subsequent load of 0x30 returns its prior contents.
